btn_debounce_array: RTL and testbench

BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

---
 rtl/btn_pkg.sv | 24 ++
 rtl/btn_debounce_ch.sv | 104 ++++++++++
 rtl/btn_debounce_array.sv | 43 ++++
 tb/tb_btn_debounce_array.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared defaults and counter sizing for the button debounce array.
package btn_pkg;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_DEB_CYCLES    = 50000;
   localparam int DEF_LONG_CYCLES   = 25000000;
   localparam int DEF_REPEAT_CYCLES = 5000000;
   localparam int DEF_ACTIVE_LOW    = 1;

   // Per-channel event pulses, registered together.
   typedef struct packed {
      logic press;
      logic rel;
      logic long_evt;
      logic rpt;
   } btn_evt_t;

   // Bits needed to hold values 0..max_val without wrapping.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce, hold/long-press and auto-repeat.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
   input  logic clk,
   input  logic reset,
   input  logic ext_btn,
   input  logic repeat_en,
   output logic level,
   output logic press,
   output logic rel,
   output logic long_evt,
   output logic rpt
);

   localparam int DEB_W  = cnt_width(DEB_CYCLES - 1);
   localparam int HOLD_W = cnt_width(LONG_CYCLES);
   localparam int REP_W  = cnt_width(REPEAT_CYCLES - 1);

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);
   localparam logic              IDLE_PIN  = (ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   level_q, level_d;
   logic [DEB_W-1:0]       deb_q, deb_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [REP_W-1:0]       rep_q, rep_d;
   btn_evt_t               evt_q, evt_d;
   logic                   s;
   logic                   toggle;

   assign s = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

   always_comb begin
      // NOTE: every value written here gets a default first, so no path can infer a latch.
      sync_d  = {sync_q[SYNC_STAGES-2:0], ext_btn};
      level_d = level_q;
      deb_d   = '0;
      hold_d  = '0;
      rep_d   = '0;
      evt_d   = '0;
      toggle  = 1'b0;

      if (s != level_q) begin
         if (deb_q == DEB_LAST) begin
            toggle      = 1'b1;
            level_d     = ~level_q;
            evt_d.press = ~level_q;
            evt_d.rel   = level_q;
         end else begin
            deb_d = deb_q + DEB_W'(1);
         end
      end

      // A release edge clears hold/repeat and wins over a coincident long or repeat.
      if (level_q && !toggle) begin
         hold_d         = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
         evt_d.long_evt = (hold_q == HOLD_LAST);
         if (repeat_en && (hold_q == HOLD_MAX)) begin
            if (rep_q == REP_LAST) begin
               evt_d.rpt = 1'b1;
            end else begin
               rep_d = rep_q + REP_W'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the synchroniser reloads the idle pin level so reset never looks like an edge.
         sync_q  <= {SYNC_STAGES{IDLE_PIN}};
         level_q <= 1'b0;
         deb_q   <= '0;
         hold_q  <= '0;
         rep_q   <= '0;
         evt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         rep_q   <= rep_d;
         evt_q   <= evt_d;
      end
   end

   assign level    = level_q;
   assign press    = evt_q.press;
   assign rel      = evt_q.rel;
   assign long_evt = evt_q.long_evt;
   assign rpt      = evt_q.rpt;

endmodule

// File: rtl/btn_debounce_array.sv
// Array of independent debounced button channels with press/release/long/repeat events.
module btn_debounce_array
   import btn_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [N_CH-1:0] iExtBtn,
   input  logic [N_CH-1:0] iRepeatEn,
   output logic [N_CH-1:0] oLevel,
   output logic [N_CH-1:0] oPress,
   output logic [N_CH-1:0] oRelease,
   output logic [N_CH-1:0] oLong,
   output logic [N_CH-1:0] oRepeat
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .DEB_CYCLES   (DEB_CYCLES),
         .LONG_CYCLES  (LONG_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES),
         .ACTIVE_LOW   (ACTIVE_LOW)
      ) u_ch (
         .clk      (CLK),
         .reset    (RESET),
         .ext_btn  (iExtBtn[g]),
         .repeat_en(iRepeatEn[g]),
         .level    (oLevel[g]),
         .press    (oPress[g]),
         .rel      (oRelease[g]),
         .long_evt (oLong[g]),
         .rpt      (oRepeat[g])
      );
   end

endmodule

// File: tb/tb_btn_debounce_array.sv
// Directed self-checking bench for btn_debounce_array with short debounce/hold timings.
module tb_btn_debounce_array;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] iExtBtn;
   logic [3:0] iRepeatEn;
   logic [3:0] oLevel, oPress, oRelease, oLong, oRepeat;

   int checks = 0;
   int errors = 0;

   btn_debounce_array #(
      .N_CH(4), .SYNC_STAGES(2), .DEB_CYCLES(4),
      .LONG_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1)
   ) dut (
      .CLK(CLK), .RESET(RESET), .iExtBtn(iExtBtn), .iRepeatEn(iRepeatEn),
      .oLevel(oLevel), .oPress(oPress), .oRelease(oRelease),
      .oLong(oLong), .oRepeat(oRepeat)
   );

   always #5 CLK = ~CLK;

   // Advance one rising edge, then park on the falling edge to sample and drive.
   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic settle(input int n);
      iExtBtn   = 4'b1111;
      iRepeatEn = 4'b0000;
      repeat (n) step();
   endtask

   task automatic test_reset();
      logic [19:0] obs;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) RESET = 1'b0;
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset k=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, 20'h0);
         end
         step();
      end
   endtask

   // Ch0 press: oPress at edge 6, release after edge 8 accepted at edge 14.
   task automatic test_press();
      logic [19:0] obs, exp;
      iExtBtn[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         exp = {((k >= 6 && k < 14) ? 4'b0001 : 4'b0000),
                (k == 6  ? 4'b0001 : 4'b0000),
                (k == 14 ? 4'b0001 : 4'b0000), 4'b0000, 4'b0000};
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL press_ch0 edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, exp);
         end
         if (k == 8) iExtBtn[0] = 1'b1;
      end
   endtask

   // Ch1 low for 3 cycles is too short to be accepted.
   task automatic test_glitch();
      logic [19:0] obs;
      iExtBtn[1] = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         step();
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== 20'h0) begin
            errors++;
            $display("FAIL glitch_ch1 edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, 20'h0);
         end
         if (k == 3) iExtBtn[1] = 1'b1;
      end
   endtask

   // Ch2 held 20 cycles with repeat: press 6, long 16, repeats 19/22/25, release 26.
   task automatic test_long_repeat();
      logic [19:0] obs, exp;
      iExtBtn[2]   = 1'b0;
      iRepeatEn[2] = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         step();
         exp = {((k >= 6 && k < 26) ? 4'b0100 : 4'b0000),
                (k == 6  ? 4'b0100 : 4'b0000),
                (k == 26 ? 4'b0100 : 4'b0000),
                (k == 16 ? 4'b0100 : 4'b0000),
                ((k == 19 || k == 22 || k == 25) ? 4'b0100 : 4'b0000)};
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL long_repeat_ch2 edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, exp);
         end
         if (k == 20) iExtBtn[2] = 1'b1;
      end
   endtask

   // Repeat enable dropped for edges 18-19 restarts the period: repeats 22/25/28.
   task automatic test_repeat_gate();
      logic [19:0] obs, exp;
      iExtBtn[2]   = 1'b0;
      iRepeatEn[2] = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         step();
         exp = {((k >= 6 && k < 30) ? 4'b0100 : 4'b0000),
                (k == 6  ? 4'b0100 : 4'b0000),
                (k == 30 ? 4'b0100 : 4'b0000),
                (k == 16 ? 4'b0100 : 4'b0000),
                ((k == 22 || k == 25 || k == 28) ? 4'b0100 : 4'b0000)};
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL repeat_gate_ch2 edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, exp);
         end
         if (k == 17) iRepeatEn[2] = 1'b0;
         if (k == 19) iRepeatEn[2] = 1'b1;
         if (k == 24) iExtBtn[2] = 1'b1;
      end
   endtask

   // Ch0 and ch3 in the same cycle report together.
   task automatic test_back_to_back();
      logic [19:0] obs, exp;
      iExtBtn = 4'b0110;
      for (int k = 1; k <= 18; k++) begin
         step();
         exp = {((k >= 6 && k < 14) ? 4'b1001 : 4'b0000),
                (k == 6  ? 4'b1001 : 4'b0000),
                (k == 14 ? 4'b1001 : 4'b0000), 4'b0000, 4'b0000};
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL simultaneous_ch0_ch3 edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, exp);
         end
         if (k == 8) iExtBtn = 4'b1111;
      end
   endtask

   // Reset mid-hold aborts silently; re-press 6 edges after reset drops, long 10 after that.
   task automatic test_reset_mid_hold();
      logic [19:0] obs, exp;
      iExtBtn[0] = 1'b0;
      repeat (8) step();
      checks++;
      if (oLevel !== 4'b0001) begin
         errors++;
         $display("FAIL pre_reset_level got %b required %b", oLevel, 4'b0001);
      end
      RESET = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         step();
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid_hold in_reset=%0d got lvl/prs/rel/lng/rpt=%b required %b", k, obs, 20'h0);
         end
      end
      RESET = 1'b0;
      for (int j = 1; j <= 26; j++) begin
         step();
         exp = {((j >= 6 && j < 24) ? 4'b0001 : 4'b0000),
                (j == 6  ? 4'b0001 : 4'b0000),
                (j == 24 ? 4'b0001 : 4'b0000),
                (j == 16 ? 4'b0001 : 4'b0000), 4'b0000};
         obs = {oLevel, oPress, oRelease, oLong, oRepeat};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL reset_mid_hold edge=%0d got lvl/prs/rel/lng/rpt=%b required %b", j, obs, exp);
         end
         if (j == 18) iExtBtn[0] = 1'b1;
      end
   endtask

   initial begin
      RESET     = 1'b1;
      iExtBtn   = 4'b1111;
      iRepeatEn = 4'b0000;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      test_reset();
      settle(4);
      test_press();
      settle(4);
      test_glitch();
      settle(4);
      test_long_repeat();
      settle(4);
      test_repeat_gate();
      settle(4);
      test_back_to_back();
      settle(4);
      test_reset_mid_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
